spi_cmd_sequencer: RTL
======================

# spi_cmd_sequencer

Command sequencer downstream of the SPI ingress byte stream, after its clock-domain-crossing FIFO. Parses each byte stream into header, address and length fields, then runs burst writes to or burst reads from the on-chip 8-bit register bus. Read data returns as an AXIS byte stream routed to the requester that sent the command.

## Interface
- `AXIS_SOURCE`, default 1: constant driven on `m_axis_tid`.
- `DEST_WIDTH`, default 8: width of the tdest ports.
- `ID_WIDTH`, default 8: width of the tid ports.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `s_axis_tdata`  in  8  command/data byte from the ingress.
- `s_axis_tvalid`  in  1  ingress byte valid.
- `s_axis_tready`  out  1  byte accepted when high together with `s_axis_tvalid`.
- `s_axis_tid`  in  ID_WIDTH  source of the byte; latched with the header.
- `frame_abort`  in  1  one-cycle pulse, chip-select deassert already synchronized to `clk`.
- `reg_addr`  out  8  register address.
- `reg_wdata`  out  8  register write data.
- `reg_wr`  out  1  one-cycle write strobe.
- `reg_rd`  out  1  one-cycle read strobe.
- `reg_rdata`  in  8  read data, valid exactly one cycle after `reg_rd`.
- `m_axis_tdata`  out  8  read-back byte.
- `m_axis_tvalid`  out  1  read-back byte valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tdest`  out  DEST_WIDTH  latched `s_axis_tid`, zero-extended or truncated.
- `m_axis_tid`  out  ID_WIDTH  equal to `AXIS_SOURCE`.
- `busy`  out  1  high whenever the state is not HDR.
- `err_cmd`  out  1  one-cycle pulse: header carried an illegal command.
- `err_abort`  out  1  one-cycle pulse: `frame_abort` arrived while the state was not HDR.

## Operation
- **Header byte.** Bits [7:6] are the command: 00 NOP, 01 WRITE, 10 READ, 11 illegal. Bits [5:0] are ignored.
- **Command byte order.** HDR, then ADDR, then LEN, then payload. LEN holds N-1, so a command moves 1..256 bytes.
- **States:** HDR, ADDR, LEN, WDATA, RISSUE, RWAIT, ROUT, DRAIN.
- **HDR:**
  - NOP: stay in HDR.
  - WRITE or READ: latch the command and `s_axis_tid`, go to ADDR.
  - Illegal (11): pulse `err_cmd`, go to DRAIN.
- **ADDR:** load the address register, go to LEN.
- **LEN:** load the count register.
  - WRITE: go to WDATA.
  - READ: go to RISSUE.
- **WDATA:** on each accepted byte:
  - next cycle: `reg_wr`=1, with `reg_addr` = current address and `reg_wdata` = the byte.
  - address increments.
  - if count==0, go to HDR; otherwise count decrements.
- **RISSUE:** `reg_rd`=1 for one cycle, go to RWAIT.
- **RWAIT:** capture `reg_rdata` into `m_axis_tdata`, set `m_axis_tvalid`, go to ROUT.
- **ROUT:** hold tdata and tvalid until `m_axis_tready`. Then:
  - tvalid drops and the address increments.
  - if count==0, go to HDR; otherwise count decrements and go to RISSUE.
- **DRAIN:** accept and discard bytes until `frame_abort`, then go to HDR.
- **Address and count arithmetic:** both are 8-bit. The address wraps 0xFF -> 0x00 inside a burst. The count is unsigned and is never decremented below 0.
- **`s_axis_tready`:** 1 in HDR, ADDR, LEN, WDATA and DRAIN; 0 in RISSUE, RWAIT and ROUT.
- **`frame_abort`:**
  - In any state except ROUT: go to HDR on the next edge. A byte handshaken in the same cycle is discarded and has no register side effect.
  - In ROUT: the pending beat is kept until `m_axis_tready`, then go to HDR.
  - `err_abort` pulses if the state was not HDR.
  - No partial command survives an abort.

## Timing
- **Reset values:** state = HDR; `s_axis_tready`=1; `m_axis_tvalid`=0; `m_axis_tdata`=0x00; `m_axis_tdest`=0; `reg_addr`=0x00; `reg_wdata`=0x00; `reg_wr`=0; `reg_rd`=0; `busy`=0; `err_cmd`=0; `err_abort`=0.
- **Write latency:** handshake at edge k gives `reg_wr` high during cycle k+1. Write throughput is 1 byte per cycle.
- **Read latency:**
  - minimum: `reg_rd` at cycle c gives `m_axis_tvalid` high at cycle c+2.
  - with `m_axis_tready` held high: 3 cycles per byte.
- **AXIS rule:** `m_axis_tvalid` never drops without a handshake, including under reset-free abort.
- **Reset mid-burst:** all outputs return to reset values immediately (asynchronous). Partially received commands are lost.

## Test plan
- **Write burst:** stream 0x40, 0x10, 0x02, 0xAA, 0xBB, 0xCC -> `reg_wr` pulses at addresses 0x10, 0x11, 0x12 with data AA, BB, CC. State returns to HDR and `busy`=0.
- **Read burst with wrap and backpressure:**
  - stimulus: stream 0x80, 0xFE, 0x02 from tid 0x03; register model returns addr^0x55; `m_axis_tready` held low for 4 cycles on the first beat.
  - required: reads at FE, FF, 00; output AB, AA, 55 with tdest=0x03; tvalid stable during the stall; `s_axis_tready`=0 throughout.
- **Illegal command:** stream 0xC0, 0x12, 0x34, then `frame_abort` -> one `err_cmd` pulse; no `reg_wr` or `reg_rd`; the next 0x00 is treated as a NOP in HDR.
- **Abort mid-write:** stream 0x40, 0x20, 0x05, 0x11, then `frame_abort` coinciding with byte 0x22 -> only one write (0x20 <- 0x11); one `err_abort` pulse; state returns to HDR.
- **Abort in ROUT with `m_axis_tready`=0:** beat is held until ready; then state goes to HDR with no further `reg_rd`.
- **Async reset during a read burst:** all outputs show reset values in the same cycle; a fresh write command then works.

Source files
------------

// File: rtl/spi_cmd_sequencer.sv
// Parses SPI ingress command bytes (header, address, length, payload) and runs
// burst writes/reads on the 8-bit register bus; read data returns over AXIS.
module spi_cmd_sequencer #(
    parameter int unsigned AXIS_SOURCE = 1,
    parameter int unsigned DEST_WIDTH  = 8,
    parameter int unsigned ID_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [ID_WIDTH-1:0]   s_axis_tid,
    input  logic                  frame_abort,

    output logic [7:0]            reg_addr,
    output logic [7:0]            reg_wdata,
    output logic                  reg_wr,
    output logic                  reg_rd,
    input  logic [7:0]            reg_rdata,

    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic [ID_WIDTH-1:0]   m_axis_tid,

    output logic                  busy,
    output logic                  err_cmd,
    output logic                  err_abort
);

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_BAD   = 2'b11;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_ADDR,
        ST_LEN,
        ST_WDATA,
        ST_RISSUE,
        ST_RWAIT,
        ST_ROUT,
        ST_DRAIN
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] addr;
    logic [7:0] cnt;
    logic       is_read;
    logic       abort_pend;
    logic       s_hs;
    logic       m_hs;
    logic [1:0] hdr_cmd;

    assign s_hs       = s_axis_tvalid && s_axis_tready;
    assign m_hs       = m_axis_tvalid && m_axis_tready;
    assign hdr_cmd    = s_axis_tdata[7:6];
    assign m_axis_tid = ID_WIDTH'(AXIS_SOURCE);

    function automatic logic accepts_bytes(input state_t st);
        return (st == ST_HDR) || (st == ST_ADDR) || (st == ST_LEN) ||
               (st == ST_WDATA) || (st == ST_DRAIN);
    endfunction

    // Next-state decode; an abort outside ROUT always returns to HDR.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_HDR: begin
                if (s_hs && !frame_abort) begin
                    case (hdr_cmd)
                        CMD_WRITE, CMD_READ: state_nxt = ST_ADDR;
                        CMD_BAD:             state_nxt = ST_DRAIN;
                        default:             state_nxt = ST_HDR;
                    endcase
                end
            end
            ST_ADDR: begin
                if (frame_abort)  state_nxt = ST_HDR;
                else if (s_hs)    state_nxt = ST_LEN;
            end
            ST_LEN: begin
                if (frame_abort)  state_nxt = ST_HDR;
                else if (s_hs)    state_nxt = is_read ? ST_RISSUE : ST_WDATA;
            end
            ST_WDATA: begin
                if (frame_abort)              state_nxt = ST_HDR;
                else if (s_hs && cnt == 8'd0) state_nxt = ST_HDR;
            end
            ST_RISSUE: state_nxt = frame_abort ? ST_HDR : ST_RWAIT;
            ST_RWAIT:  state_nxt = frame_abort ? ST_HDR : ST_ROUT;
            ST_ROUT: begin
                // The pending beat must complete before any abort takes effect.
                if (m_hs) begin
                    if (frame_abort || abort_pend || cnt == 8'd0) state_nxt = ST_HDR;
                    else                                          state_nxt = ST_RISSUE;
                end
            end
            ST_DRAIN: begin
                if (frame_abort) state_nxt = ST_HDR;
            end
            default: state_nxt = ST_HDR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_HDR;
            addr          <= 8'h00;
            cnt           <= 8'h00;
            is_read       <= 1'b0;
            abort_pend    <= 1'b0;
            s_axis_tready <= 1'b1;
            busy          <= 1'b0;
            reg_addr      <= 8'h00;
            reg_wdata     <= 8'h00;
            reg_wr        <= 1'b0;
            reg_rd        <= 1'b0;
            m_axis_tdata  <= 8'h00;
            m_axis_tvalid <= 1'b0;
            m_axis_tdest  <= '0;
            err_cmd       <= 1'b0;
            err_abort     <= 1'b0;
        end else begin
            state         <= state_nxt;
            busy          <= (state_nxt != ST_HDR);
            s_axis_tready <= accepts_bytes(state_nxt);
            reg_wr        <= 1'b0;
            reg_rd        <= (state_nxt == ST_RISSUE);
            err_cmd       <= 1'b0;
            err_abort     <= frame_abort && (state != ST_HDR);
            abort_pend    <= (state_nxt == ST_ROUT) &&
                             (abort_pend || ((state == ST_ROUT) && frame_abort));

            case (state)
                ST_HDR: begin
                    if (s_hs && !frame_abort) begin
                        if (hdr_cmd == CMD_WRITE || hdr_cmd == CMD_READ) begin
                            is_read      <= (hdr_cmd == CMD_READ);
                            m_axis_tdest <= DEST_WIDTH'(s_axis_tid);
                        end
                        if (hdr_cmd == CMD_BAD) begin
                            err_cmd <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (s_hs && !frame_abort) begin
                        addr <= s_axis_tdata;
                    end
                end
                ST_LEN: begin
                    if (s_hs && !frame_abort) begin
                        cnt      <= s_axis_tdata;
                        reg_addr <= addr;
                    end
                end
                ST_WDATA: begin
                    if (s_hs && !frame_abort) begin
                        reg_wr    <= 1'b1;
                        reg_addr  <= addr;
                        reg_wdata <= s_axis_tdata;
                        addr      <= addr + 8'd1;
                        if (cnt != 8'd0) begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                end
                ST_RWAIT: begin
                    if (!frame_abort) begin
                        m_axis_tdata  <= reg_rdata;
                        m_axis_tvalid <= 1'b1;
                    end
                end
                ST_ROUT: begin
                    if (m_hs) begin
                        m_axis_tvalid <= 1'b0;
                        addr          <= addr + 8'd1;
                        reg_addr      <= addr + 8'd1;
                        if (cnt != 8'd0) begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
